// File: rtl/four_bit_adder.sv
// Registered 4-bit adder slice: sum, carry-out, signed overflow, zero and
// group propagate/generate flags, all captured on the rising clock edge.
module four_bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout,
  output logic       OVF,
  output logic       Z,
  output logic       P,
  output logic       G
);

  logic [3:0] bit_p;
  logic [3:0] bit_g;
  logic [4:0] carry;
  logic [3:0] sum;
  logic       ovf_next;
  logic       zero_next;
  logic       grp_p;
  logic       grp_g;

  assign bit_p = A ^ B;
  assign bit_g = A & B;

  // Four full-adder slices chained through the ripple carry.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      carry[i+1] = bit_g[i] | (bit_p[i] & carry[i]);
      sum[i]     = bit_p[i] ^ carry[i];
    end
  end

  // Group terms are flattened lookahead products so they never see Cin.
  always_comb begin
    grp_p = &bit_p;
    grp_g = bit_g[3]
          | (bit_p[3] & bit_g[2])
          | (bit_p[3] & bit_p[2] & bit_g[1])
          | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
  end

  // Overflow is the disagreement between carries into and out of the sign bit.
  assign ovf_next  = carry[4] ^ carry[3];
  assign zero_next = (sum == 4'd0);

  // NOTE: state uses non-blocking assignments; the async reset clears
  // every output immediately, and Z resets to 1 to stay consistent with S=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= 4'd0;
      Cout <= 1'b0;
      OVF  <= 1'b0;
      Z    <= 1'b1;
      P    <= 1'b0;
      G    <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= carry[4];
      OVF  <= ovf_next;
      Z    <= zero_next;
      P    <= grp_p;
      G    <= grp_g;
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed vectors with literal
// expectations plus an arithmetic reference model checked every cycle.
module tb_four_bit_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       OVF;
  logic       Z;
  logic       P;
  logic       G;

  int checks = 0;
  int errors = 0;

  four_bit_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .OVF  (OVF),
    .Z    (Z),
    .P    (P),
    .G    (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result packed as {cout, s[3:0], ovf, z, p, g}, from plain arithmetic.
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
    int total, sa, sb, ss;
    logic [3:0] s;
    total = int'(a) + int'(b) + int'(c);
    s     = total[3:0];
    sa    = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb    = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    ss    = sa + sb + int'(c);
    return {total > 15, s, (ss > 7) || (ss < -8), s == 4'd0,
            (a ^ b) == 4'hF, (int'(a) + int'(b)) > 15};
  endfunction

  function automatic logic [8:0] outs();
    return {Cout, S, OVF, Z, P, G};
  endfunction

  // Every-cycle compare: operands seen at the edge must appear 1 ns later.
  always @(posedge clk) begin
    logic [3:0] a_s, b_s;
    logic       c_s, r_s;
    a_s = A;
    b_s = B;
    c_s = Cin;
    r_s = rst_n;
    #1;
    if (!r_s) check("cycle_reset", outs(), 9'b0_0000_0100);
    else      check($sformatf("cycle_%0d_%0d_%0d", a_s, b_s, c_s), outs(), model(a_s, b_s, c_s));
  end

  // Drive at a falling edge, then check the registered result one falling edge later.
  task automatic vec(input string name, input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic [3:0] es, input logic ec, input logic eo, input logic ez,
                     input logic ep, input logic eg);
    A = a;
    B = b;
    Cin = c;
    @(negedge clk);
    check(name, outs(), {ec, es, eo, ez, ep, eg});
  endtask

  initial begin
    rst_n = 1'b0;
    A     = 4'd9;
    B     = 4'd6;
    Cin   = 1'b0;

    check("model_pin_4_7_1",   model(4'd4, 4'd7, 1'b1),   {1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0});
    check("model_pin_15_15_0", model(4'd15, 4'd15, 1'b0), {1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b1});

    // Reset held across several edges with live operands.
    repeat (3) @(negedge clk);
    check("reset_hold", outs(), 9'b0_0000_0100);
    rst_n = 1'b1;

    //   name         A      B      Cin   S      Cout  OVF   Z     P     G
    vec("add_0_0_0",  4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vec("add_0_1_1",  4'd0,  4'd1,  1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("add_0_2_0",  4'd0,  4'd2,  1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("add_2_4_1",  4'd2,  4'd4,  1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec("add_3_6_0",  4'd3,  4'd6,  1'b0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vec("ovf_4_7_1",  4'd4,  4'd7,  1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vec("prop_9_6_0", 4'd9,  4'd6,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec("cout_15_15", 4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vec("cout_15_1",  4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    vec("chain_cin1", 4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vec("chain_cin0", 4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-stream asynchronous reset: outputs must clear before any edge.
    A = 4'd15;
    B = 4'd15;
    Cin = 1'b0;
    @(posedge clk);
    #3;
    check("pre_async_reset", outs(), {1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b0;
    #1;
    check("async_reset_now", outs(), 9'b0_0000_0100);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release captures the operands already present.
    vec("post_reset", 4'd5, 4'd10, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Exhaustive sweep, one combination per cycle; the compare process checks each.
    for (int i = 0; i < 512; i++) begin
      A   = i[3:0];
      B   = i[7:4];
      Cin = i[8];
      @(negedge clk);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
